add_acc_unit: RTL and testbench

Parametrised streaming adder/subtractor/accumulator. It replaces the bench-level `add()` task (fixed 4-bit a + b into a 5-bit y) with a synthesizable block. Each accepted operand pair is either summed, subtracted, or folded into a multi-beat accumulation. Results come back through a registered valid/ready output. The block sits between a stimulus/operand source and any downstream consumer of arithmetic results.

---
 rtl/add_acc_if.sv | 28 ++
 rtl/add_acc_unit.sv | 137 +++++++++++++
 tb/tb_add_acc_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/add_acc_if.sv
// Operand/result stream bundle for add_acc_unit: operand beats in, registered results out.
interface add_acc_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_y;
  logic             out_ovf;
  logic [CNT_W-1:0] out_beats;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_ovf, out_beats
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_y, out_ovf, out_beats
  );
endinterface

// File: rtl/add_acc_unit.sv
// Streaming add / subtract / multi-beat accumulate unit with a registered
// valid/ready result stage. The accumulator is held in IDLE/ACCUM states.
module add_acc_unit #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  add_acc_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             vld_q, vld_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  logic             accept;
  logic [ACC_W-1:0] pair_sum;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Two's-complement difference of unsigned operands, wrapped to ACC_W bits.
  function automatic logic [ACC_W-1:0] sub_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [ACC_W:0] diff;
    diff = $signed({1'b0, ACC_W'(a)}) - $signed({1'b0, ACC_W'(b)});
    return diff[ACC_W-1:0];
  endfunction

  assign bus.in_ready  = !vld_q || bus.out_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_y     = y_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_beats = beats_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign pair_sum = ACC_W'(bus.in_a) + ACC_W'(bus.in_b);
  // One extra bit is enough: acc + a + b < 2^(ACC_W+1) because ACC_W >= WIDTH+1.
  assign acc_sum  = {1'b0, acc_q} + (ACC_W+1)'(bus.in_a) + (ACC_W+1)'(bus.in_b);
  assign cnt_inc  = sat_inc(cnt_q);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    vld_d    = vld_q && !bus.out_ready;
    y_d      = y_q;
    ovf_d    = ovf_q;
    beats_d  = beats_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          unique case (bus.in_mode)
            MODE_ADD: begin
              y_d     = pair_sum;
              ovf_d   = 1'b0;
              beats_d = CNT_W'(1);
              vld_d   = 1'b1;
            end
            MODE_SUB: begin
              y_d     = sub_wrap(bus.in_a, bus.in_b);
              ovf_d   = (bus.in_a < bus.in_b);
              beats_d = CNT_W'(1);
              vld_d   = 1'b1;
            end
            MODE_ACC: begin
              acc_d    = pair_sum;
              cnt_d    = CNT_W'(1);
              sticky_d = 1'b0;
              if (bus.in_last) begin
                y_d     = pair_sum;
                ovf_d   = 1'b0;
                beats_d = CNT_W'(1);
                vld_d   = 1'b1;
              end else begin
                state_d = ACCUM;
              end
            end
            default: ;
          endcase
        end
        ACCUM: begin
          acc_d    = acc_sum[ACC_W-1:0];
          sticky_d = sticky_q | acc_sum[ACC_W];
          cnt_d    = cnt_inc;
          if (bus.in_last) begin
            y_d     = acc_sum[ACC_W-1:0];
            ovf_d   = sticky_q | acc_sum[ACC_W];
            beats_d = cnt_inc;
            vld_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      vld_q    <= 1'b0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      vld_q    <= vld_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      beats_q  <= beats_d;
    end
  end

endmodule

// File: tb/tb_add_acc_unit.sv
// Directed bench for add_acc_unit: ADD/SUB/ACC results, saturation, backpressure, reset abort.
module tb_add_acc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  add_acc_if #(.WIDTH(4), .ACC_W(8), .CNT_W(4)) bus ();

  add_acc_unit #(.WIDTH(4), .ACC_W(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one beat across a single posedge; outputs are sampled 1 time unit later.
  task automatic beat(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] mode, input logic last);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_mode  = mode;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] y,
                         input logic o, input logic [3:0] n);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_y"},     32'(bus.out_y),     32'(y));
    chk({tag, "_ovf"},   32'(bus.out_ovf),   32'(o));
    chk({tag, "_beats"}, 32'(bus.out_beats), 32'(n));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = 2'b00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    chk_out("reset", 1'b0, 8'd0, 1'b0, 4'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADD, back-to-back so the second result replaces the first without a bubble
    beat(4'd15, 4'd15, 2'b00, 1'b0);
    chk_out("add_15_15", 1'b1, 8'd30, 1'b0, 4'd1);
    beat(4'd1, 4'd3, 2'b00, 1'b0);
    chk_out("add_1_3", 1'b1, 8'd4, 1'b0, 4'd1);
    @(posedge clk); #1;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    beat(4'd3, 4'd5, 2'b01, 1'b0);
    chk_out("sub_3_5", 1'b1, 8'hFE, 1'b1, 4'd1);
    beat(4'd9, 4'd4, 2'b01, 1'b0);
    chk_out("sub_9_4", 1'b1, 8'd5, 1'b0, 4'd1);

    // ACC packet; mode on beat 2 is ignored while accumulating
    beat(4'd1, 4'd3, 2'b10, 1'b0);
    chk("acc3_b1_valid", 32'(bus.out_valid), 32'd0);
    beat(4'd5, 4'd6, 2'b00, 1'b0);
    chk("acc3_b2_valid", 32'(bus.out_valid), 32'd0);
    beat(4'd7, 4'd8, 2'b10, 1'b1);
    chk_out("acc3", 1'b1, 8'd30, 1'b0, 4'd3);

    // 20 beats of 15+15: wraps past 255 and the beat count saturates
    for (int i = 0; i < 19; i++) begin
      beat(4'd15, 4'd15, 2'b10, 1'b0);
      chk("acc20_mid_valid", 32'(bus.out_valid), 32'd0);
    end
    beat(4'd15, 4'd15, 2'b10, 1'b1);
    chk_out("acc20", 1'b1, 8'd88, 1'b1, 4'd15);
    @(posedge clk); #1;

    // Backpressure
    bus.out_ready = 1'b0;
    beat(4'd2, 4'd2, 2'b00, 1'b0);
    chk_out("bp_add", 1'b1, 8'd4, 1'b0, 4'd1);
    bus.in_a     = 4'd7;
    bus.in_b     = 4'd8;
    bus.in_mode  = 2'b11;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_y",   32'(bus.out_y),    32'd4);
      chk("bp_hold_vld", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_mode11_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    beat(4'd7, 4'd8, 2'b00, 1'b0);
    chk_out("bp_add_7_8", 1'b1, 8'd15, 1'b0, 4'd1);
    @(posedge clk); #1;

    // Reset in the middle of an accumulation, between clock edges
    beat(4'd5, 4'd5, 2'b10, 1'b0);
    beat(4'd6, 4'd6, 2'b10, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 8'd0, 1'b0, 4'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    beat(4'd1, 4'd3, 2'b00, 1'b0);
    chk_out("post_rst_add", 1'b1, 8'd4, 1'b0, 4'd1);
    beat(4'd2, 4'd1, 2'b10, 1'b1);
    chk_out("post_rst_acc1", 1'b1, 8'd3, 1'b0, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required $finish before 100000");
    $fatal(1);
  end
endmodule
